// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM type and sizing helpers for the ADC capture path
package adc_pkg;
  typedef enum logic [1:0] {IDLE, REQ, CONV} state_t;
  function automatic int acc_width(int bits, int avg_log2);
    return bits + avg_log2;
  endfunction
  function automatic int ptr_width(int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/adc_fifo.sv
// adc_fifo: synchronous show-ahead FIFO with a registered head that holds when empty
//   clk, reset_n (async active-low); push/wdata write side; pop/rdata read side;
//   full/empty status. A push on full is accepted only when a pop happens the same cycle.
module adc_fifo
  import adc_pkg::*;
#(
  parameter int BITS  = 6,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [BITS-1:0] wdata,
  output logic [BITS-1:0] rdata,
  output logic            full,
  output logic            empty
);
  localparam int PW = ptr_width(DEPTH);
  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] cnt, left;
  logic wr, rd;
  assign full  = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  // entries of the old contents still queued after this cycle's pop
  assign left  = cnt - (PW+1)'(rd);
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      rdata  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(rd);
      wr_ptr <= wr_ptr + PW'(wr);
      cnt    <= left + (PW+1)'(wr);
      if (left != '0) rdata <= mem[rd_ptr + PW'(rd)];
      else if (wr) rdata <= wdata;
    end
endmodule

// File: rtl/adc_capture.sv
// adc_capture: paces SAR ADC conversions, averages 2**AVG_LOG2 results and queues the averages
//   clk, reset_n (async active-low); enable gates new conversions; clear drops sticky flags
//   and the partial average; start/done/result talk to the ADC control block;
//   data/valid/ready is the output stream; overflow and timed_out are sticky flags.
//   Define ADC_CAPTURE_ROUND_EN for round-half-up with saturation instead of truncation.
module adc_capture
  import adc_pkg::*;
#(
  parameter int BITS     = 6,
  parameter int PERIOD   = 16,
  parameter int AVG_LOG2 = 2,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            clear,
  input  logic            done,
  input  logic [BITS-1:0] result,
  output logic            start,
  output logic [BITS-1:0] data,
  output logic            valid,
  input  logic            ready,
  output logic            overflow,
  output logic            timed_out
);
  localparam int AW = acc_width(BITS, AVG_LOG2);
  localparam int PW = PERIOD > 2 ? $clog2(PERIOD) : 1;
  localparam int TW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  localparam int SW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  state_t state, next;
  logic done_q, rise, go, timeout_hit, sample, last, push, pop, full, empty;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [AW-1:0] acc, sum;
  logic [SW-1:0] scount;
  logic [BITS-1:0] avg;
  assign rise        = done & ~done_q;
  assign go          = enable & (pcnt == '0) & ~clear;
  assign timeout_hit = tcnt == TW'(TIMEOUT - 1);
  assign sample      = (state == CONV) & rise & ~clear;
  assign last        = scount == SW'((1 << AVG_LOG2) - 1);
  assign sum         = acc + AW'(result);
  assign push        = sample & last;
  assign pop         = valid & ready;
  assign valid       = ~empty;
`ifdef ADC_CAPTURE_ROUND_EN
  logic [AW:0] rnd, shr;
  assign rnd = {1'b0, sum} + (AW+1)'((1 << AVG_LOG2) >> 1);
  assign shr = rnd >> AVG_LOG2;
  assign avg = (shr > (AW+1)'((1 << BITS) - 1)) ? '1 : shr[BITS-1:0];
`else
  assign avg = sum[AW-1:AVG_LOG2];
`endif
  always_comb
    next = (state == IDLE && go) ? REQ :
           (state == REQ) ? CONV :
           (state == CONV && (rise || timeout_hit)) ? IDLE : state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      start     <= 1'b0;
      pcnt      <= '0;
      tcnt      <= '0;
      acc       <= '0;
      scount    <= '0;
      overflow  <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= next;
      done_q    <= done;
      start     <= next == REQ;
      // reload alongside the registered start so successive starts are exactly PERIOD apart
      pcnt      <= (next == REQ) ? PW'(PERIOD - 1) : (pcnt != '0) ? pcnt - 1'b1 : pcnt;
      tcnt      <= (state == REQ) ? '0 : (state == CONV) ? tcnt + 1'b1 : tcnt;
      if (clear) begin
        acc    <= '0;
        scount <= '0;
      end else if (sample) begin
        acc    <= last ? '0 : sum;
        scount <= last ? '0 : scount + 1'b1;
      end
      overflow  <= ~clear & (overflow | (push & full & ~pop));
      timed_out <= ~clear & (timed_out | ((state == CONV) & ~rise & timeout_hit));
    end
  adc_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .wdata  (avg),
    .rdata  (data),
    .full   (full),
    .empty  (empty)
  );
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: randomized and directed checks of adc_capture against a queue-based reference model
module tb_adc_capture;
  localparam int BITS = 6, PERIOD = 16, AVG_LOG2 = 2, DEPTH = 4, TIMEOUT = 64;
  localparam int N = 1 << AVG_LOG2;
  logic clk = 0, reset_n = 0, enable = 0, clear = 0, done = 0, ready = 0;
  logic [BITS-1:0] result = '0;
  logic start, valid, overflow, timed_out;
  logic [BITS-1:0] data;
  adc_capture #(.BITS(BITS), .PERIOD(PERIOD), .AVG_LOG2(AVG_LOG2), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .done(done), .result(result),
    .start(start), .data(data), .valid(valid), .ready(ready), .overflow(overflow), .timed_out(timed_out)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int exp_q[$], samples[$], fixed[$];
  bit m_ov, m_to, in_conv, prev_done, respond = 1, pop_on_push, last_en, last_clr;
  int last_data, conv_n, dly, hold, cyc, rise_cyc, last_start = -1, start_cnt, pops, avg_made;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int avg_of(int s[$]);
    int sum = 0;
    foreach (s[i]) sum += s[i];
`ifdef ADC_CAPTURE_ROUND_EN
    sum = (sum + N / 2) / N;
    return sum > (1 << BITS) - 1 ? (1 << BITS) - 1 : sum;
`else
    return sum / N;
`endif
  endfunction
  task automatic adc_drive();
    if (pop_on_push) ready = 0;
    if (start && respond) dly = $urandom_range(1, 8);
    else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        done = 1;
        result = BITS'(fixed.size() != 0 ? fixed.pop_front() : $urandom_range(0, (1 << BITS) - 1));
        hold = $urandom_range(0, 1);
        rise_cyc = cyc;
        if (pop_on_push && samples.size() == N - 1 && exp_q.size() == DEPTH && !clear) ready = 1;
      end
    end else if (hold > 0) hold--;
    else done = 0;
  endtask
  task automatic model_edge();
    bit pop, rs;
    pop = exp_q.size() != 0 && ready;
    rs = done && !prev_done && in_conv;
    prev_done = done;
    last_en = enable;
    last_clr = clear;
    if (pop) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (clear) begin
      samples.delete();
      m_ov = 0;
      m_to = 0;
    end else if (rs) begin
      samples.push_back(int'(result));
      if (samples.size() == N) begin
        avg_made++;
        if (exp_q.size() < DEPTH) exp_q.push_back(avg_of(samples));
        else m_ov = 1;
        samples.delete();
      end
    end
    if (in_conv) begin
      if (rs) in_conv = 0;
      else if (++conv_n == TIMEOUT) begin
        in_conv = 0;
        if (!clear) m_to = 1;
      end
    end
    if (start) begin
      in_conv = 1;
      conv_n = 0;
    end
    if (exp_q.size() != 0) last_data = exp_q[0];
  endtask
  task automatic check_outputs();
    check("valid", valid, exp_q.size() != 0);
    check("data", data, last_data);
    check("overflow", overflow, m_ov);
    check("timed_out", timed_out, m_to);
    if (in_conv) check("start_in_conv", start, 0);
    if (start) begin
      start_cnt++;
      check("start_gate", last_en && !last_clr, 1);
      if (last_start >= 0) check("start_gap", cyc - last_start >= PERIOD, 1);
      last_start = cyc;
    end
  endtask
  task automatic cycle();
    adc_drive();
    model_edge();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic wait_start(int bound);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!start && n < bound);
    check("wait_start", start, 1);
  endtask
  task automatic pulse_clear();
    clear = 1;
    cycle();
    clear = 0;
  endtask
  task automatic async_reset();
    #2 reset_n = 0;
    #1;
    check("rst_start", start, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timed_out", timed_out, 0);
    exp_q.delete();
    samples.delete();
    {m_ov, m_to, in_conv, prev_done, done, enable, clear} = '0;
    {last_data, conv_n, dly, hold} = '0;
    last_start = -1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, t0, s0, target, prev;
    @(negedge clk);
    @(negedge clk);
    check("reset_start", start, 0);
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_overflow", overflow, 0);
    check("reset_timed_out", timed_out, 0);
    reset_n = 1;
    // single average from a known sample sequence
    fixed = '{10, 11, 12, 13};
    enable = 1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_start(40);
      if (k > 0) check("t1_gap", cyc - prev, PERIOD);
      prev = cyc;
    end
    enable = 0;
    s0 = start_cnt;
    n = 0;
    while (!valid && n < 30) begin
      cycle();
      n++;
    end
    check("t1_latency", cyc - rise_cyc, 1);
`ifdef ADC_CAPTURE_ROUND_EN
    check("t1_data", data, 12);
`else
    check("t1_data", data, 11);
`endif
    run(30);
    check("t1_no_extra_start", start_cnt - s0, 0);
    ready = 1;
    run(5);
    // backpressure: five averages into a four-entry queue
    ready = 0;
    enable = 1;
    target = avg_made + 5;
    n = 0;
    while (avg_made < target && n < 600) begin
      cycle();
      n++;
    end
    check("t2_avgs_done", avg_made >= target, 1);
    enable = 0;
    run(20);
    check("t2_overflow", overflow, 1);
    check("t2_valid", valid, 1);
    pops = 0;
    ready = 1;
    run(12);
    check("t2_drained", pops, DEPTH);
    // full queue with a pop landing on the push cycle
    pulse_clear();
    check("t3_ov_cleared", overflow, 0);
    ready = 0;
    enable = 1;
    pop_on_push = 1;
    target = avg_made + 5;
    n = 0;
    while (avg_made < target && n < 600) begin
      cycle();
      n++;
    end
    pop_on_push = 0;
    ready = 0;
    enable = 0;
    run(20);
    check("t3_no_overflow", overflow, 0);
    pops = 0;
    ready = 1;
    run(12);
    check("t3_drained", pops, DEPTH);
    // timeout between accepted samples leaves the partial sum intact
    pulse_clear();
    fixed = '{30, 31, 32, 33};
    enable = 1;
    n = 0;
    while (samples.size() < 2 && n < 100) begin
      cycle();
      n++;
    end
    respond = 0;
    wait_start(40);
    t0 = cyc;
    n = 0;
    while (!timed_out && n < TIMEOUT + 10) begin
      cycle();
      n++;
    end
    check("t4_to_time", cyc - t0 >= TIMEOUT && cyc - t0 <= TIMEOUT + 1, 1);
    respond = 1;
    wait_start(40);
    check("t4_restart_gap", cyc - t0 >= PERIOD, 1);
    target = avg_made + 1;
    n = 0;
    while (avg_made < target && n < 100) begin
      cycle();
      n++;
    end
    cycle();
`ifdef ADC_CAPTURE_ROUND_EN
    check("t4_avg", data, 32);
`else
    check("t4_avg", data, 31);
`endif
    // enable dropped right after a start; clear discards the lone sample
    pulse_clear();
    fixed = '{5};
    wait_start(40);
    cycle();
    enable = 0;
    s0 = start_cnt;
    run(40);
    check("t5_no_start", start_cnt - s0, 0);
    pulse_clear();
    fixed = '{20, 21, 22, 23};
    enable = 1;
    target = avg_made + 1;
    n = 0;
    while (avg_made < target && n < 100) begin
      cycle();
      n++;
    end
    cycle();
`ifdef ADC_CAPTURE_ROUND_EN
    check("t5_avg", data, 22);
`else
    check("t5_avg", data, 21);
`endif
    // asynchronous reset in the middle of a conversion
    respond = 0;
    wait_start(40);
    cycle();
    cycle();
    async_reset();
    respond = 1;
    s0 = start_cnt;
    run(30);
    check("t6_no_start", start_cnt - s0, 0);
    enable = 1;
    cycle();
    check("t6_start", start, 1);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      enable = $urandom_range(0, 15) != 0;
      clear = $urandom_range(0, 63) == 0;
      ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      cycle();
    end
    clear = 0;
    enable = 0;
    ready = 1;
    run(60);
    check("final_empty", valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Sits directly downstream of the SAR ADC control block and also drives its Start input.
- Issues conversion requests at a programmed rate and captures each Result when Done rises.
- Averages 2**AvgLog2 consecutive samples and queues the averages in a small FIFO.
- Presents the queue to the rest of the digital design over a Valid/Ready interface.

Parameters:
- Bits, 6, ADC result width; must match the ADC control block.
- Period, 16, minimum clocks between successive Start pulses; >= 2.
- AvgLog2, 2, log2 of samples per average; 0 = no averaging.
- Depth, 4, FIFO depth in entries; power of two, >= 2.
- Timeout, 64, max clocks from Start to Done rising before abort.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- Enable  in  1  allow new conversions.
- Clear  in  1  synchronous; clears Overflow, TimedOut, accumulator and sample count.
- Done  in  1  from ADC control.
- Result  in  Bits  from ADC control; valid while Done is high.
- Start  out  1  to ADC control; registered, one-cycle pulse.
- Data  out  Bits  FIFO head.
- Valid  out  1  FIFO not empty.
- Ready  in  1  consumer accepts Data when Valid&&Ready.
- Overflow  out  1  sticky; an average was dropped because the FIFO was full.
- TimedOut  out  1  sticky; a conversion exceeded Timeout.

Behaviour:
- Reset (async, Reset_n=0):
  - Outputs: Start=0, Valid=0, Data=0, Overflow=0, TimedOut=0.
  - Internal: FSM=IDLE, period counter=0, accumulator=0, sample count=0, FIFO empty, Done_q=0.
  - Reset mid-conversion abandons that conversion; the partial average is lost.
- Edge detect: Done_q registers Done every cycle; a rise is Done && !Done_q.
- Period counter: reloads to Period-1 on each Start, decrements to 0, then holds at 0.
- FSM states IDLE, REQ, CONV:
  - IDLE -> REQ when Enable=1, counter=0 and Clear=0. Start=1 during REQ (exactly one cycle).
  - REQ -> CONV unconditionally. The timeout counter loads 0.
  - CONV -> IDLE on Done rise: Result is added to the accumulator and the sample count is incremented.
  - CONV -> IDLE when the timeout counter reaches Timeout-1 with no rise: TimedOut=1 and no sample is added.
  - A Done rise outside CONV is ignored.
- Enable deassert: the FSM leaves IDLE only with Enable=1. A conversion already in REQ/CONV completes and is accumulated.
- Accumulator width is Bits+AvgLog2; it cannot overflow.
- When the sample count wraps (2**AvgLog2 samples collected):
  - avg = acc >> AvgLog2 (truncate).
  - avg is pushed the same cycle the last sample is added; acc and count are then reset.
- FIFO:
  - Push on empty: Valid=1 the next cycle (latency 1 from the Done-rise cycle to Valid).
  - Pop when Valid&&Ready: Data advances next cycle.
  - Push on full without a simultaneous pop: the average is dropped and Overflow=1.
  - Push on full with a simultaneous pop: accepted, and the count stays full.
  - Push and pop on empty: not possible, because Valid=0.
- Clear: takes priority over accumulation in the same cycle, so a sample landing on a Clear cycle is discarded. The FIFO is not flushed and the FSM is not disturbed.
- Data holds its last value when Valid=0.

Optional Feature:
- Macro ADC_CAPTURE_ROUND_EN.
- Defined: avg = min((acc + 2**(AvgLog2-1)) >> AvgLog2, 2**Bits-1), i.e. round-half-up with saturation. For AvgLog2=0 the result is identical to truncation.
- Undefined: truncation as specified above.

Decomposition:
- Package adc_pkg:
  - FSM state enum (IDLE, REQ, CONV).
  - Helper to compute accumulator width Bits+AvgLog2.
  - FIFO pointer width $clog2(Depth).
- Sub-module adc_fifo:
  - Synchronous, show-ahead, parameterised Bits/Depth.
  - push/pop/full/empty, async active-low reset.
  - Used once here and reusable by other converters.

Test Plan:
- Single average (Bits=6, AvgLog2=2, Period=16; ADC model returns 10,11,12,13):
  - Exactly 4 Start pulses, 16 clocks apart.
  - Data=11 (truncate) or 12 (ADC_CAPTURE_ROUND_EN), Valid=1 one cycle after the 4th Done rise.
- Backpressure: Ready=0, Depth=4, 5 averages produced -> Valid=1 with 4 entries, Overflow=1. Then Ready=1 drains exactly 4 entries in order.
- Full with simultaneous pop: FIFO full, Ready=1 on the push cycle -> no Overflow, count stays 4.
- Timeout: ADC model never raises Done -> TimedOut=1 at Start+Timeout cycles. The FSM then issues the next Start after Period, and the accumulator is unchanged.
- Enable dropped one cycle after Start -> the current conversion is accumulated, no further Start occurs, and Clear zeroes a sample count of 1.
- Reset_n pulsed low mid-CONV, asynchronous to Clk -> all outputs 0 immediately. After release, no Start until Enable=1, then Start on the next counter=0.
